// File: rtl/risc_pkg.sv
// Shared constants, FSM state type and decode helper for the register-bank
// write-back arbiter.
package risc_pkg;

   localparam int WORD_W     = 16;
   localparam int NUM_REGS   = 8;
   localparam int ADDR_W     = $clog2(NUM_REGS);
   localparam int MEM_STREAK = 3;
   localparam bit ZERO_R0    = 1'b1;

   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Register index to one-hot file_reg enable vector.
   function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] idx);
      logic [NUM_REGS-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the two requesters and the arbiter, plus the
// enable/data path towards the file_reg bank.
interface regfile_wb_arbiter_if;
   import risc_pkg::*;

   logic                alu_valid;
   logic [ADDR_W-1:0]   alu_addr;
   logic [WORD_W-1:0]   alu_data;
   logic                alu_ready;
   logic                mem_valid;
   logic [ADDR_W-1:0]   mem_addr;
   logic [WORD_W-1:0]   mem_data;
   logic                mem_ready;
   logic [NUM_REGS-1:0] reg_en;
   logic [WORD_W-1:0]   reg_d;
   logic                busy;

   modport slave (
      input  alu_valid, alu_addr, alu_data,
      input  mem_valid, mem_addr, mem_data,
      output alu_ready, mem_ready, reg_en, reg_d, busy
   );

   modport master (
      output alu_valid, alu_addr, alu_data,
      output mem_valid, mem_addr, mem_data,
      input  alu_ready, mem_ready, reg_en, reg_d, busy
   );

endinterface

// File: rtl/wb_fair_sel.sv
// Grant selection between ALU and MEM write-back requests. MEM normally wins
// contention; after STREAK_MAX consecutive contended MEM grants the ALU is
// given the next contended slot so it cannot starve.
module wb_fair_sel
   import risc_pkg::*;
#(
   parameter int STREAK_MAX = MEM_STREAK
) (
   input  logic clk,
   input  logic reset,
   input  logic i_en,
   input  logic i_alu_valid,
   input  logic i_mem_valid,
   output logic o_alu_grant,
   output logic o_mem_grant
);

   localparam int            SW    = $clog2(STREAK_MAX + 1);
   localparam logic [SW-1:0] W_MAX = SW'(STREAK_MAX);

   logic [SW-1:0] r_streak;
   logic [SW-1:0] w_streak_nxt;

   // Same-cycle grant decision and next streak value.
   always_comb begin
      o_alu_grant  = 1'b0;
      o_mem_grant  = 1'b0;
      w_streak_nxt = '0;
      if (!i_en) begin
         w_streak_nxt = '0;
      end else if (i_alu_valid && i_mem_valid) begin
         if (r_streak == W_MAX) begin
            o_alu_grant  = 1'b1;
            w_streak_nxt = '0;
         end else begin
            o_mem_grant  = 1'b1;
            w_streak_nxt = (r_streak < W_MAX) ? (r_streak + SW'(1)) : W_MAX;
         end
      end else if (i_alu_valid) begin
         o_alu_grant = 1'b1;
      end else if (i_mem_valid) begin
         o_mem_grant = 1'b1;
      end else begin
         w_streak_nxt = '0;
      end
   end

   // Contended-MEM streak register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_streak <= '0;
      end else begin
         r_streak <= w_streak_nxt;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back controller for the register bank: zero-sweeps every register
// after reset, then arbitrates ALU/MEM write-backs onto the single registered
// enable/data path feeding the file_reg instances.
module regfile_wb_arbiter
   import risc_pkg::*;
(
   input logic                 clk,
   input logic                 reset,
   regfile_wb_arbiter_if.slave bus
);

   state_e              r_state;
   state_e              w_state_nxt;
   logic [ADDR_W-1:0]   r_sweep_idx;
   logic [NUM_REGS-1:0] r_reg_en;
   logic [WORD_W-1:0]   r_reg_d;

   logic                w_run;
   logic                w_sweep_last;
   logic                w_alu_grant;
   logic                w_mem_grant;
   logic                w_alu_xfer;
   logic                w_mem_xfer;
   logic                w_wr_any;
   logic                w_wr_fire;
   logic [ADDR_W-1:0]   w_wr_addr;
   logic [WORD_W-1:0]   w_wr_data;

   assign w_run        = (r_state == RUN);
   assign w_sweep_last = (r_sweep_idx == ADDR_W'(NUM_REGS - 1));

   wb_fair_sel #(
      .STREAK_MAX (MEM_STREAK)
   ) u_fair_sel (
      .clk         (clk),
      .reset       (reset),
      .i_en        (w_run),
      .i_alu_valid (bus.alu_valid),
      .i_mem_valid (bus.mem_valid),
      .o_alu_grant (w_alu_grant),
      .o_mem_grant (w_mem_grant)
   );

   assign w_alu_xfer    = bus.alu_valid & w_alu_grant;
   assign w_mem_xfer    = bus.mem_valid & w_mem_grant;

   assign bus.alu_ready = w_alu_grant;
   assign bus.mem_ready = w_mem_grant;
   assign bus.reg_en    = r_reg_en;
   assign bus.reg_d     = r_reg_d;
   assign bus.busy      = (r_state == INIT);

   // Next-state logic: leave the sweep once the last register has been cleared.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         INIT: begin
            if (w_sweep_last) begin
               w_state_nxt = RUN;
            end else begin
               w_state_nxt = INIT;
            end
         end
         RUN:     w_state_nxt = RUN;
         default: w_state_nxt = INIT;
      endcase
   end

   // Mux the accepted request onto the write path; R0 writes are swallowed.
   always_comb begin
      w_wr_any  = 1'b0;
      w_wr_addr = '0;
      w_wr_data = '0;
      if (w_mem_xfer) begin
         w_wr_any  = 1'b1;
         w_wr_addr = bus.mem_addr;
         w_wr_data = bus.mem_data;
      end else if (w_alu_xfer) begin
         w_wr_any  = 1'b1;
         w_wr_addr = bus.alu_addr;
         w_wr_data = bus.alu_data;
      end else begin
         w_wr_any  = 1'b0;
      end
      w_wr_fire = w_wr_any && !(ZERO_R0 && (w_wr_addr == ADDR_W'(0)));
   end

   // State, sweep counter and the registered enable/data stage to the bank.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= INIT;
         r_sweep_idx <= '0;
         r_reg_en    <= '0;
         r_reg_d     <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            INIT: begin
               r_reg_en    <= onehot(r_sweep_idx);
               r_reg_d     <= '0;
               r_sweep_idx <= r_sweep_idx + ADDR_W'(1);
            end
            RUN: begin
               if (w_wr_fire) begin
                  r_reg_en <= onehot(w_wr_addr);
                  r_reg_d  <= w_wr_data;
               end else begin
                  r_reg_en <= '0;
               end
            end
            default: begin
               r_reg_en <= '0;
            end
         endcase
      end
   end

endmodule
